// File: rtl/cmos_capture_pkg.sv
// Shared definitions for the CMOS capture / luma front end.
package cmos_capture_pkg;

  // Luma weights; they sum to 256, so the shifted sum always fits in 8 bits
  localparam logic [7:0] COEF_R  = 8'd77;
  localparam logic [7:0] COEF_G  = 8'd150;
  localparam logic [7:0] COEF_B  = 8'd29;
  localparam int unsigned Y_SHIFT = 8;

  typedef enum logic {
    SKIP = 1'b0,
    RUN  = 1'b1
  } skip_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // RGB565 -> RGB888 by replicating the top bits into the new LSBs
  function automatic rgb888_t rgb565_expand(input logic [15:0] p);
    rgb888_t c;
    c.r = {p[15:11], p[15:13]};
    c.g = {p[10:5],  p[10:9]};
    c.b = {p[4:0],   p[4:2]};
    return c;
  endfunction

endpackage

// File: rtl/cmos_capture_y_rgb565_to_y.sv
// RGB565 pixel to 8-bit luma: expand, multiply, sum/shift. Fixed 3-cycle latency.
module rgb565_to_y
  import cmos_capture_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_vld,
  input  logic [15:0] pix,
  output logic        y_vld,
  output logic [7:0]  y
);

  localparam int STAGES = 3;

  logic [STAGES:1] vld_pipe;
  rgb888_t         rgb_q;
  logic [15:0]     pr_q, pg_q, pb_q;
  logic [16:0]     sum;

  assign sum   = {1'b0, pr_q} + {1'b0, pg_q} + {1'b0, pb_q};
  assign y_vld = vld_pipe[STAGES];

  // valid travels alongside the data through all three stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:1], pix_vld};
  end

  // expand, multiply, then sum/shift; data forced to 0 when not valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
      pr_q  <= '0;
      pg_q  <= '0;
      pb_q  <= '0;
      y     <= '0;
    end else begin
      rgb_q <= pix_vld ? rgb565_expand(pix) : '0;
      pr_q  <= 16'(rgb_q.r) * 16'(COEF_R);
      pg_q  <= 16'(rgb_q.g) * 16'(COEF_G);
      pb_q  <= 16'(rgb_q.b) * 16'(COEF_B);
      y     <= vld_pipe[2] ? 8'(sum >> Y_SHIFT) : 8'd0;
    end
  end

endmodule

// File: rtl/cmos_capture_y.sv
// DVP RGB565 capture with start-up frame skip and luma conversion.
// Optional per-frame size check enabled by defining CMOS_CAPTURE_SIZE_CHK_EN.
module cmos_capture_y
  import cmos_capture_pkg::*;
#(
  parameter logic [9:0] IMG_HDISP  = 10'd640,
  parameter logic [9:0] IMG_VDISP  = 10'd480,
  parameter logic [3:0] FRAME_SKIP = 4'd10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmos_vsync,
  input  logic       cmos_href,
  input  logic [7:0] cmos_data,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_Y,
  output logic       frame_size_err
);

  localparam skip_state_e ST_RST = (FRAME_SKIP == 4'd0) ? RUN : SKIP;

  logic        vs_r, hs_r;
  logic [7:0]  d_r;
  logic [2:0]  vs_dly, hs_dly;
  logic        phase;
  logic [7:0]  byte_hold;
  skip_state_e state;
  logic [3:0]  skip_cnt;
  logic        run, vs_rise, pix_vld;
  logic [15:0] pix;

  assign run     = (state == RUN);
  assign vs_rise = vs_r & ~vs_dly[0];
  assign pix_vld = hs_r & phase & run;
  assign pix     = {byte_hold, d_r};

  assign post_frame_vsync = vs_dly[2];
  assign post_frame_href  = hs_dly[2];

  // register raw sensor pins before any use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r <= 1'b0;
      hs_r <= 1'b0;
      d_r  <= '0;
    end else begin
      vs_r <= cmos_vsync;
      hs_r <= cmos_href;
      d_r  <= cmos_data;
    end
  end

  // sync delay lines match the 3-stage conversion; href is blanked while skipping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_dly <= '0;
      hs_dly <= '0;
    end else begin
      vs_dly <= {vs_dly[1:0], vs_r};
      hs_dly <= {hs_dly[1:0], hs_r & run};
    end
  end

  // byte phase: hold the first byte, pair on the second; a dangling byte dies with href
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= 1'b0;
      byte_hold <= '0;
    end else if (!hs_r) begin
      phase <= 1'b0;
    end else begin
      phase <= ~phase;
      if (!phase) byte_hold <= d_r;
    end
  end

  // frame-skip FSM: count vsync rises, switch to RUN in blanking, stay there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RST;
      skip_cnt <= '0;
    end else if (state == SKIP && vs_rise) begin
      skip_cnt <= skip_cnt + 4'd1;
      if (skip_cnt + 4'd1 == FRAME_SKIP) state <= RUN;
    end
  end

  rgb565_to_y u_rgb565_to_y (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_vld(pix_vld),
    .pix    (pix),
    .y_vld  (post_frame_clken),
    .y      (post_img_Y)
  );

`ifdef CMOS_CAPTURE_SIZE_CHK_EN
  logic        hs_q, href_fall, size_err;
  logic [10:0] pix_cnt;
  logic [9:0]  line_cnt;

  assign href_fall      = hs_q & ~hs_r;
  assign frame_size_err = size_err;

  // pixels per line and lines per frame, checked only once frames are live
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q     <= 1'b0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      size_err <= 1'b0;
    end else begin
      hs_q <= hs_r;
      if (!run) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
      end else begin
        if (pix_vld) pix_cnt <= pix_cnt + 11'd1;
        if (href_fall) begin
          if (pix_cnt != {1'b0, IMG_HDISP}) size_err <= 1'b1;
          pix_cnt  <= '0;
          line_cnt <= line_cnt + 10'd1;
        end
        if (vs_rise) begin
          if (line_cnt != IMG_VDISP) size_err <= 1'b1;
          line_cnt <= '0;
        end
      end
    end
  end
`else
  assign frame_size_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmos_capture_y.sv
// Three DUTs (FRAME_SKIP 0/1/2, 4x2 image) share one randomized byte stream;
// every output is compared each cycle against a history-based reference model.
module tb_cmos_capture_y;

  localparam int MAXN = 4096;
`ifdef CMOS_CAPTURE_SIZE_CHK_EN
  localparam bit SZ_EN = 1'b1;
`else
  localparam bit SZ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmos_vsync = 1'b0, cmos_href = 1'b0;
  logic [7:0] cmos_data = 8'd0;
  logic [2:0] o_vs, o_hs, o_ck, o_err;
  logic [2:0][7:0] o_y;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cmos_capture_y #(
      .IMG_HDISP (10'd4),
      .IMG_VDISP (10'd2),
      .FRAME_SKIP(4'(g))
    ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cmos_vsync      (cmos_vsync),
      .cmos_href       (cmos_href),
      .cmos_data       (cmos_data),
      .post_frame_vsync(o_vs[g]),
      .post_frame_href (o_hs[g]),
      .post_frame_clken(o_ck[g]),
      .post_img_Y      (o_y[g]),
      .frame_size_err  (o_err[g])
    );
  end

  always #5 clk = ~clk;

  bit         vs_h[MAXN], hs_h[MAXN];
  logic [7:0] d_h[MAXN];
  int n = 0, seg = 0;
  int checks = 0, failures = 0;
  int ck_cnt[3], hs_cnt[3], vr_cnt[3], pcnt[3], lcnt[3];
  bit pvs[3], err_m[3];
  bit cap = 0;
  int ycap[$];

  function automatic bit mvs(input int i);
    return (i >= seg && i < n) ? vs_h[i] : 1'b0;
  endfunction

  function automatic bit mhs(input int i);
    return (i >= seg && i < n) ? hs_h[i] : 1'b0;
  endfunction

  // live when enough vsync rises have been seen since reset, before sample s
  function automatic bit run_at(input int s, input int skip);
    int rises = 0;
    if (skip == 0) return 1'b1;
    for (int j = seg; j < s; j++) if (mvs(j) && !mvs(j-1)) rises++;
    return rises >= skip;
  endfunction

  // second byte = even position within the current href-high run
  function automatic bit second_byte(input int s);
    int len = 0;
    for (int j = s; j >= seg && mhs(j); j--) len++;
    return (len > 0) && (len % 2 == 0);
  endfunction

  function automatic int luma(input logic [7:0] b1, input logic [7:0] b2);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(b1[7:3]);
    g6 = int'({b1[2:0], b2[7:5]});
    b5 = int'(b2[4:0]);
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return (77 * r8 + 150 * g8 + 29 * b8) / 256;
  endfunction

  task automatic err_update(input int k, input int p);
    if (!run_at(p, k)) begin
      pcnt[k] = 0;
      lcnt[k] = 0;
    end else begin
      if (second_byte(p)) pcnt[k]++;
      if (mhs(p-1) && !mhs(p)) begin
        if (pcnt[k] != 4) err_m[k] = 1'b1;
        pcnt[k] = 0;
        lcnt[k]++;
      end
      if (mvs(p) && !mvs(p-1)) begin
        if (lcnt[k] != 2) err_m[k] = 1'b1;
        lcnt[k] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    checks++;
  endtask

  // outputs after edge e reflect sample e-3; the size flag reflects samples up to e-1
  task automatic check_outputs();
    int s, p;
    s = n - 4;
    p = n - 2;
    for (int k = 0; k < 3; k++) begin
      bit ev, eh, ec, r;
      logic [7:0] ey;
      ev = 0; eh = 0; ec = 0; r = 0; ey = 8'd0;
      if (s >= seg) begin
        r  = run_at(s, k);
        ev = mvs(s);
        eh = mhs(s) && r;
        ec = second_byte(s) && r;
        if (ec) ey = 8'(luma(d_h[s-1], d_h[s]));
      end
      if (p >= seg) err_update(k, p);
      assert ({o_vs[k], o_hs[k], o_ck[k], o_y[k]} === {ev, eh, ec, ey}) else begin
        failures++;
        $error("FAIL stream dut%0d cyc=%0d observed vs/hs/ck/Y=%b/%b/%b/%0d expected=%b/%b/%b/%0d",
               k, n, o_vs[k], o_hs[k], o_ck[k], o_y[k], ev, eh, ec, ey);
      end
      checks++;
      assert (o_err[k] === (SZ_EN & err_m[k])) else begin
        failures++;
        $error("FAIL size_err dut%0d cyc=%0d observed=%b expected=%b", k, n, o_err[k], SZ_EN & err_m[k]);
      end
      checks++;
      if (o_ck[k] === 1'b1) ck_cnt[k]++;
      if (o_hs[k] === 1'b1) hs_cnt[k]++;
      if (o_vs[k] === 1'b1 && !pvs[k]) vr_cnt[k]++;
      pvs[k] = (o_vs[k] === 1'b1);
      if (k == 0 && cap && o_ck[0] === 1'b1) ycap.push_back(int'(o_y[0]));
    end
  endtask

  task automatic step(input bit v, input bit h, input logic [7:0] d);
    cmos_vsync = v;
    cmos_href  = h;
    cmos_data  = d;
    @(posedge clk);
    vs_h[n] = v; hs_h[n] = h; d_h[n] = d;
    n++;
    #1;
    check_outputs();
  endtask

  task automatic send_bytes(input logic [63:0] w, input int nb);
    for (int i = 0; i < nb; i++) step(1'b0, 1'b1, w[63-8*i -: 8]);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic rand_line(input int nb);
    logic [63:0] w;
    w = {$urandom, $urandom};
    send_bytes(w, nb);
  endtask

  task automatic vsync_pulse();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic rand_frame();
    rand_line(8);
    rand_line(8);
    vsync_pulse();
  endtask

  task automatic clr_cnt();
    for (int k = 0; k < 3; k++) begin
      ck_cnt[k] = 0; hs_cnt[k] = 0; vr_cnt[k] = 0;
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      assert ({o_vs[k], o_hs[k], o_ck[k], o_y[k], o_err[k]} === 12'd0) else begin
        failures++;
        $error("FAIL %s dut%0d observed vs/hs/ck/Y/err=%b/%b/%b/%0d/%b expected all 0",
               tag, k, o_vs[k], o_hs[k], o_ck[k], o_y[k], o_err[k]);
      end
      checks++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_zero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_hold");
    cmos_href = 1'b0;
    rst_n = 1'b1;
    seg = n;
    for (int k = 0; k < 3; k++) begin
      err_m[k] = 0; pcnt[k] = 0; lcnt[k] = 0; pvs[k] = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_y[4];
    exp_y[0] = 255; exp_y[1] = 76; exp_y[2] = 149; exp_y[3] = 28;
    clr_cnt();

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_state");
    rst_n = 1'b1;
    seg = 0;

    // frame 1: colour line + random line
    clr_cnt();
    cap = 1;
    send_bytes(64'hFFFF_F800_07E0_001F, 8);
    cap = 0;
    rand_line(8);
    vsync_pulse();
    chk("colour_count", ycap.size(), 4);
    for (int i = 0; i < 4 && i < ycap.size(); i++) chk($sformatf("colour_y%0d", i), ycap[i], exp_y[i]);
    chk("f1_skip0_ck", ck_cnt[0], 8);
    chk("f1_skip1_ck", ck_cnt[1], 0);
    chk("f1_skip2_ck", ck_cnt[2], 0);
    chk("f1_skip2_hs", hs_cnt[2], 0);
    chk("f1_skip2_vs", vr_cnt[2], 1);

    // frames 2 and 3
    clr_cnt();
    rand_frame();
    chk("f2_skip1_ck", ck_cnt[1], 8);
    chk("f2_skip2_ck", ck_cnt[2], 0);
    chk("f2_skip2_hs", hs_cnt[2], 0);
    chk("f2_skip2_vs", vr_cnt[2], 1);
    clr_cnt();
    rand_frame();
    chk("f3_skip2_ck", ck_cnt[2], 8);
    chk("f3_skip2_vs", vr_cnt[2], 1);

    // short line of 3 pixels
    rand_line(6);
    for (int k = 0; k < 3; k++) chk($sformatf("short_line_err%0d", k), int'(o_err[k]), int'(SZ_EN));

    // odd byte count, then a normal line that must pair from its first byte
    clr_cnt();
    rand_line(5);
    chk("odd_line_ck", ck_cnt[0], 2);
    rand_line(8);
    vsync_pulse();

    // a correct frame leaves the sticky flag set
    rand_frame();
    for (int k = 0; k < 3; k++) chk($sformatf("sticky_err%0d", k), int'(o_err[k]), int'(SZ_EN));

    // reset in the middle of a line
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'($urandom));
    do_reset();
    clr_cnt();
    rand_frame();
    chk("rst_f1_skip0_ck", ck_cnt[0], 8);
    chk("rst_f1_skip1_ck", ck_cnt[1], 0);
    chk("rst_f1_skip1_vs", vr_cnt[1], 1);
    clr_cnt();
    rand_frame();
    chk("rst_f2_skip1_ck", ck_cnt[1], 8);
    chk("rst_f2_err0", int'(o_err[0]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
